binary_gcd_unit: RTL and testbench

- Parametrised, multi-cycle greatest-common-divisor engine using the binary (Stein) algorithm.
- Uses shifts and subtractions only, with no divider.
- Replaces the 16-bit subtraction-only GCD in the Lab5 datapath.
- Adds width and done-hold parameters, a busy flag, and a per-operation iteration counter for performance checks.

---
 rtl/binary_gcd_unit.sv | 147 ++++++++++++++
 tb/tb_binary_gcd_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_gcd_unit.sv
// ============================================================================
//  Module   : binary_gcd_unit
//  Purpose  : Multi-cycle binary (Stein) GCD engine: shifts and subtracts only.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_gcd_unit #(
  parameter int WIDTH       = 16,
  parameter int DONE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic [CNT_W-1:0] cycles
);

  localparam int K_W    = $clog2(WIDTH + 1);
  localparam int HOLD_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REDUCE = 2'd1;
  localparam logic [1:0] S_CAL    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [K_W-1:0]    k;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold;

  logic             a_zero;
  logic             b_zero;
  logic             a_even;
  logic             b_even;
  logic             a_ge_b;
  logic             reduce_exit;
  logic             hold_last;
  logic [CNT_W-1:0] cnt_inc;

  assign a_zero      = (op_a == '0);
  assign b_zero      = (op_b == '0);
  assign a_even      = ~op_a[0];
  assign b_even      = ~op_b[0];
  assign a_ge_b      = (op_a >= op_b);
  assign reduce_exit = a_zero | b_zero | ~a_even | ~b_even;
  assign hold_last   = (hold == HOLD_W'(DONE_CYCLES - 1));
  assign cnt_inc     = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start)            state_nxt = S_REDUCE;
      S_REDUCE: if (reduce_exit)      state_nxt = S_CAL;
      S_CAL:    if (a_zero || b_zero) state_nxt = S_FINISH;
      S_FINISH: if (hold_last)        state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_REDUCE) || (state == S_CAL);
    done = (state == S_FINISH);
  end

  // Datapath: common factor of two is stripped into k, then restored on exit.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      k      <= '0;
      cnt    <= '0;
      hold   <= '0;
      gcd    <= '0;
      cycles <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            k      <= '0;
            cnt    <= '0;
            hold   <= '0;
            gcd    <= '0;
            cycles <= '0;
          end
        end
        S_REDUCE: begin
          cnt <= cnt_inc;
          if (!reduce_exit) begin
            op_a <= op_a >> 1;
            op_b <= op_b >> 1;
            k    <= k + K_W'(1);
          end
        end
        S_CAL: begin
          cnt <= cnt_inc;
          if (a_zero) begin
            gcd    <= op_b << k;
            cycles <= cnt_inc;
            hold   <= '0;
          end else if (b_zero) begin
            gcd    <= op_a << k;
            cycles <= cnt_inc;
            hold   <= '0;
          end else if (a_even) begin
            op_a <= op_a >> 1;
          end else if (b_even) begin
            op_b <= op_b >> 1;
          end else if (a_ge_b) begin
            op_a <= (op_a - op_b) >> 1;
          end else begin
            op_b <= (op_b - op_a) >> 1;
          end
        end
        S_FINISH: begin
          if (!hold_last) begin
            hold <= hold + HOLD_W'(1);
          end
        end
        default: begin
          hold <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_binary_gcd_unit.sv
// Scoreboard bench for binary_gcd_unit: a 16-bit/2-cycle-done instance and an
// 8-bit/3-cycle-done instance, each with its own expectation queue and monitor.
`default_nettype none

module tb_binary_gcd_unit;

  typedef struct {
    int g;
    int c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start16, busy16, done16;
  logic [15:0] a16, b16, gcd16;
  logic [7:0]  cyc16;
  logic        start8, busy8, done8;
  logic [7:0]  a8, b8, gcd8;
  logic [7:0]  cyc8;

  exp_t q16[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;

  binary_gcd_unit #(.WIDTH(16), .DONE_CYCLES(2), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .gcd(gcd16), .cycles(cyc16)
  );

  binary_gcd_unit #(.WIDTH(8), .DONE_CYCLES(3), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gcd(gcd8), .cycles(cyc8)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // Monitor for the 16-bit instance.
  initial begin
    int bc, dw, hg, hc;
    bit hv;
    exp_t e;
    bc = 0; dw = 0; hg = 0; hc = 0; hv = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bc = 0; dw = 0; hv = 0;
      end else begin
        if (busy16) begin
          bc++;
          hv = 0;
          chk("gcd16_cleared_while_busy", gcd16, 0);
        end
        if (done16) begin
          if (dw == 0) begin
            if (q16.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_done16: got gcd %0d expected no result", gcd16);
            end else begin
              e = q16.pop_front();
              chk("gcd16", gcd16, e.g);
              chk("cycles16", cyc16, e.c);
              chk("busy16_len", bc, e.c);
              hv = 1; hg = e.g; hc = e.c;
            end
            bc = 0;
          end
          dw++;
        end else if (dw != 0) begin
          chk("done16_width", dw, 2);
          dw = 0;
        end
        if (hv) begin
          chk("gcd16_hold", gcd16, hg);
          chk("cycles16_hold", cyc16, hc);
        end
      end
    end
  end

  // Monitor for the 8-bit instance; c < 0 means only the cycle bound is known.
  initial begin
    int bc, dw;
    exp_t e;
    bc = 0; dw = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bc = 0; dw = 0;
      end else begin
        if (busy8) bc++;
        if (done8) begin
          if (dw == 0) begin
            if (q8.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_done8: got gcd %0d expected no result", gcd8);
            end else begin
              e = q8.pop_front();
              chk("gcd8", gcd8, e.g);
              if (e.c >= 0) chk("cycles8", cyc8, e.c);
              else          chk("cycles8_bound", int'(cyc8 <= 8'd18), 1);
              chk("busy8_len", bc, int'(cyc8));
            end
            bc = 0;
          end
          dw++;
        end else if (dw != 0) begin
          chk("done8_width", dw, 3);
          dw = 0;
        end
      end
    end
  end

  task automatic wait_idle16(input string tag);
    bit seen;
    int n;
    seen = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done16) seen = 1;
      else if (seen) break;
    end
    if (n == 300) begin
      checks++; errors++;
      $display("FAIL timeout16_%s: got no completed done expected one", tag);
    end
  endtask

  task automatic wait_idle8(input string tag);
    bit seen;
    int n;
    seen = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done8) seen = 1;
      else if (seen) break;
    end
    if (n == 300) begin
      checks++; errors++;
      $display("FAIL timeout8_%s: got no completed done expected one", tag);
    end
  endtask

  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input int eg, input int ec);
    exp_t e;
    e.g = eg; e.c = ec;
    @(negedge clk);
    a16 = av; b16 = bv; start16 = 1'b1;
    q16.push_back(e);
    @(negedge clk);
    start16 = 1'b0;
    wait_idle16("run");
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input int eg, input int ec);
    exp_t e;
    e.g = eg; e.c = ec;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8("run");
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got no end of test expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    exp_t e;
    int dseen;
    logic [7:0] ra, rb;
    rst_n = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0;
    start8  = 1'b0; a8  = '0; b8  = '0;
    @(negedge clk);
    chk("rst_busy16", busy16, 0);
    chk("rst_done16", done16, 0);
    chk("rst_gcd16", gcd16, 0);
    chk("rst_cycles16", cyc16, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;

    run16(16'd48, 16'd18, 6, 8);
    repeat (3) @(negedge clk);
    run16(16'd0, 16'd0, 0, 2);
    run16(16'd0, 16'd37, 37, 2);
    run16(16'd37, 16'd0, 37, 2);
    run16(16'd1024, 16'd4096, 1024, 15);
    run16(16'd65535, 16'd1, 1, 18);
    run16(16'd1000, 16'd1000, 1000, 6);

    // start held high: one result, then a restart only after done falls
    e.g = 6; e.c = 8;
    @(negedge clk);
    a16 = 16'd48; b16 = 16'd18; start16 = 1'b1;
    q16.push_back(e);
    q16.push_back(e);
    wait_idle16("held1");
    chk("held_idle_gap_busy", busy16, 0);
    @(negedge clk);
    chk("held_restart_busy", busy16, 1);
    start16 = 1'b0;
    wait_idle16("held2");

    // asynchronous reset while a result is held
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("idle_rst_gcd16", gcd16, 0);
    chk("idle_rst_cycles16", cyc16, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;

    // asynchronous reset mid-CAL abandons the operation
    @(negedge clk);
    a16 = 16'd65535; b16 = 16'd1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (5) @(negedge clk);
    chk("midcal_busy_before", busy16, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("midcal_rst_busy", busy16, 0);
    chk("midcal_rst_done", done16, 0);
    chk("midcal_rst_gcd", gcd16, 0);
    chk("midcal_rst_cycles", cyc16, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    dseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done16) dseen++;
    end
    chk("no_done_after_reset", dseen, 0);
    run16(16'd48, 16'd18, 6, 8);

    // 8-bit instance
    run8(8'd252, 8'd105, 21, 7);
    run8(8'd0, 8'd0, 0, 2);
    run8(8'd255, 8'd255, 255, 3);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 50 == 0) ra = 8'd0;
      if (i % 50 == 25) rb = 8'd0;
      run8(ra, rb, ref_gcd(int'(ra), int'(rb)), -1);
    end

    repeat (5) @(negedge clk);
    chk("q16_drained", q16.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
